// File: rtl/note_sequencer.sv
// Pattern step sequencer feeding the synth voice with trig and osc_count.
// Internal step state is registered once more into the outputs.
module note_sequencer #(
    parameter int STEPS    = 16,
    parameter int TICK_DIV = 1200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [15:0] step_ticks,
    input  logic [15:0] gate_ticks,
    input  logic [3:0]  len,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [8:0]  wr_data,
    output logic        trig,
    output logic [7:0]  osc_count,
    output logic [3:0]  step_idx,
    output logic        busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PLAY = 1'b1;

    logic [8:0]    mem [STEPS];
    logic [0:0]    state;
    logic [PW-1:0] pre;
    logic [15:0]   tcnt;
    logic [3:0]    cur_idx;
    logic [7:0]    cur_osc;
    logic          cur_rest;

    logic          tick;
    logic [15:0]   s_m1;
    logic [15:0]   gate_eff;
    logic [3:0]    nxt_idx;
    logic [3:0]    load_idx;
    logic [8:0]    ent;

    always_comb begin
        tick     = (pre == PMAX);
        s_m1     = (step_ticks == 16'd0) ? 16'd0 : step_ticks - 16'd1;
        gate_eff = (gate_ticks < s_m1) ? gate_ticks : s_m1;
        nxt_idx  = (cur_idx >= len) ? 4'd0 : cur_idx + 4'd1;
        load_idx = (state == IDLE) ? 4'd0 : nxt_idx;
        ent      = mem[load_idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STEPS; i++) mem[i] <= 9'h100;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pre       <= '0;
            tcnt      <= 16'd0;
            cur_idx   <= 4'd0;
            cur_osc   <= 8'd0;
            cur_rest  <= 1'b1;
            trig      <= 1'b0;
            osc_count <= 8'd0;
            step_idx  <= 4'd0;
            busy      <= 1'b0;
        end else begin
            busy      <= (state == PLAY);
            step_idx  <= cur_idx;
            osc_count <= cur_osc;
            trig      <= (state == PLAY) && !cur_rest && (tcnt < gate_eff);

            unique case (state)
                IDLE: begin
                    if (run) begin
                        state    <= PLAY;
                        pre      <= '0;
                        tcnt     <= 16'd0;
                        cur_idx  <= load_idx;
                        cur_rest <= ent[8];
                        if (!ent[8]) cur_osc <= ent[7:0];
                    end
                end
                default: begin
                    if (!run) begin
                        state <= IDLE;
                    end else begin
                        pre <= tick ? '0 : pre + PW'(1);
                        // >= so a live shrink of step_ticks ends the step at once
                        if (tick && tcnt >= s_m1) begin
                            tcnt     <= 16'd0;
                            cur_idx  <= load_idx;
                            cur_rest <= ent[8];
                            if (!ent[8]) cur_osc <= ent[7:0];
                        end else if (tick) begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_DIV=4.
// Output at negedge k after run rise reflects internal step state m=k-2.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [15:0] step_ticks;
    logic [15:0] gate_ticks;
    logic [3:0]  len;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [8:0]  wr_data;
    logic        trig;
    logic [7:0]  osc_count;
    logic [3:0]  step_idx;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int k      = 0;

    note_sequencer #(.STEPS(16), .TICK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step_ticks (step_ticks),
        .gate_ticks (gate_ticks),
        .len        (len),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .trig       (trig),
        .osc_count  (osc_count),
        .step_idx   (step_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [8:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        int m;
        int st;
        int p;
        rst        = 1'b0;
        run        = 1'b0;
        step_ticks = 16'd4;
        gate_ticks = 16'd2;
        len        = 4'd1;
        wr_en      = 1'b0;
        wr_addr    = 4'd0;
        wr_data    = 9'd0;

        @(negedge clk);
        chk("rst_trig", 16'(trig), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_osc", 16'(osc_count), 16'd0);
        chk("rst_idx", 16'(step_idx), 16'd0);
        rst = 1'b1;

        wr(4'd0, 9'h042);
        repeat (100) begin
            @(negedge clk);
            chk("idle_trig", 16'(trig), 16'd0);
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_osc", 16'(osc_count), 16'd0);
        end

        // basic play
        wr(4'd1, 9'h021);
        run = 1'b1;
        k = 0;
        adv(1);
        for (int kk = 2; kk <= 65; kk++) begin
            adv(1);
            m  = kk - 2;
            st = (m / 16) % 2;
            chk("play_trig", 16'(trig), 16'((m % 16) < 8));
            chk("play_idx", 16'(step_idx), 16'(st));
            chk("play_osc", 16'(osc_count), (st == 0) ? 16'h42 : 16'h21);
            chk("play_busy", 16'(busy), 16'd1);
        end
        run = 1'b0;
        adv(3);
        chk("stop_busy", 16'(busy), 16'd0);
        chk("stop_trig", 16'(trig), 16'd0);

        // rest step and gate clamp
        wr(4'd1, 9'h100);
        gate_ticks = 16'd10;
        run = 1'b1;
        k = 0;
        adv(1);
        for (int kk = 2; kk <= 65; kk++) begin
            adv(1);
            m  = kk - 2;
            st = (m / 16) % 2;
            chk("rest_trig", 16'(trig), 16'(st == 0 && (m % 16) < 12));
            chk("rest_idx", 16'(step_idx), 16'(st));
            chk("rest_osc", 16'(osc_count), 16'h42);
        end
        run = 1'b0;
        adv(3);

        // stop in step 2, then restart
        wr(4'd1, 9'h021);
        wr(4'd2, 9'h033);
        wr(4'd3, 9'h044);
        len        = 4'd3;
        gate_ticks = 16'd2;
        run = 1'b1;
        k = 0;
        adv(36);
        chk("s2_idx", 16'(step_idx), 16'd2);
        chk("s2_trig", 16'(trig), 16'd1);
        chk("s2_osc", 16'(osc_count), 16'h33);
        run = 1'b0;
        adv(2);
        chk("halt_trig", 16'(trig), 16'd0);
        chk("halt_busy", 16'(busy), 16'd0);
        chk("halt_idx", 16'(step_idx), 16'd2);
        chk("halt_osc", 16'(osc_count), 16'h33);
        run = 1'b1;
        k = 0;
        adv(2);
        chk("re_idx", 16'(step_idx), 16'd0);
        chk("re_osc", 16'(osc_count), 16'h42);
        chk("re_trig", 16'(trig), 16'd1);
        chk("re_busy", 16'(busy), 16'd1);

        // length shrink while on step 9
        run = 1'b0;
        adv(3);
        len        = 4'd15;
        step_ticks = 16'd2;
        gate_ticks = 16'd1;
        run = 1'b1;
        k = 0;
        adv(76);
        chk("l9_idx", 16'(step_idx), 16'd9);
        chk("l9_trig", 16'(trig), 16'd0);
        len = 4'd3;
        adv(5);
        chk("l9_hold", 16'(step_idx), 16'd9);
        adv(1);
        chk("wrap_idx", 16'(step_idx), 16'd0);
        chk("wrap_trig", 16'(trig), 16'd1);
        chk("wrap_osc", 16'(osc_count), 16'h42);

        // step_ticks = 0: one tick per step, no gate
        step_ticks = 16'd0;
        adv(12);
        p = 3;
        chk("s0_idx", 16'(step_idx), 16'(p));
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                adv(1);
                chk("s0_trig", 16'(trig), 16'd0);
            end
            p = (p >= 3) ? 0 : p + 1;
            chk("s0_step", 16'(step_idx), 16'(p));
        end

        // overwrite the playing step
        run = 1'b0;
        adv(3);
        step_ticks = 16'd4;
        gate_ticks = 16'd2;
        len        = 4'd1;
        run = 1'b1;
        k = 0;
        adv(10);
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 9'h055;
        adv(1);
        wr_en = 1'b0;
        adv(1);
        chk("ow_osc_now", 16'(osc_count), 16'h42);
        chk("ow_idx_now", 16'(step_idx), 16'd0);
        adv(22);
        chk("ow_idx_next", 16'(step_idx), 16'd0);
        chk("ow_osc_next", 16'(osc_count), 16'h55);
        chk("ow_trig_next", 16'(trig), 16'd1);

        // async reset mid-gate
        adv(1);
        chk("pre_rst_trig", 16'(trig), 16'd1);
        rst = 1'b0;
        #1;
        chk("ar_trig", 16'(trig), 16'd0);
        chk("ar_busy", 16'(busy), 16'd0);
        chk("ar_osc", 16'(osc_count), 16'd0);
        chk("ar_idx", 16'(step_idx), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            adv(1);
            chk("memrest_trig", 16'(trig), 16'd0);
            chk("memrest_osc", 16'(osc_count), 16'd0);
        end
        chk("memrest_busy", 16'(busy), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Step sequencer that drives the synth voice: plays a programmable pattern of up to 16 steps by sequencing the voice's `trig` input and its oscillator half-period `osc_count`, with tempo and gate length set in ticks. It sits between the top level and the `synth` instance and replaces the fixed `trig` pin and constant `osc_count`. The ADSR and filter settings still come from the top level. Pattern memory is written through a simple synchronous write port.

## Interface
- `STEPS`, 16: pattern memory depth. Fixed at 16; index width is 4.
- `TICK_DIV`, 1200: clock cycles per sequencer tick. Must be ≥1.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `run`  in  1  level. 1 = play, 0 = stop.
- `step_ticks`  in  16  ticks per step. 0 is treated as 1.
- `gate_ticks`  in  16  ticks that `trig` stays high within a step.
- `len`  in  4  pattern length minus 1. Steps 0..`len` play.
- `wr_en`  in  1  write strobe for pattern memory.
- `wr_addr`  in  4  pattern entry to write.
- `wr_data`  in  9  bit 8 = rest; bits 7:0 = osc_count.
- `trig`  out  1  gate to synth.
- `osc_count`  out  8  oscillator half-period to synth.
- `step_idx`  out  4  step currently playing.
- `busy`  out  1  high while in PLAY.

## Operation
- Pattern memory: 16×9 flops.
  - Reset sets every entry to 9'h100 (rest, count 0).
  - A write occurs on the clock edge where `wr_en`=1. It is allowed in any state.
- Prescaler: counts 0..TICK_DIV-1 and emits a one-cycle `tick` on wrap. It is cleared when leaving IDLE.
- Effective step length: S = max(`step_ticks`, 1).
- Effective gate: G = min(`gate_ticks`, S-1).
  - There is always at least one low tick per step, so the synth sees a rising edge on consecutive notes.
  - S=1 means `trig` is never asserted.
- The FSM has two states: IDLE and PLAY.
- IDLE:
  - `trig`=0 and `busy`=0.
  - `step_idx` and `osc_count` hold their last values.
  - When `run`=1 is sampled: load step 0, clear the tick counter `tcnt` and the prescaler, and go to PLAY.
- Step load (entry e = mem[idx]):
  - `step_idx` ← idx.
  - If e[8]=0: `osc_count` ← e[7:0].
  - If e[8]=1 (rest): `osc_count` is held, so the release tail keeps its pitch.
- PLAY:
  - `busy`=1.
  - `trig` = 1 when `tcnt` < G and the current entry is not a rest. This is registered and updated on the cycle after `tcnt` changes.
  - On `tick`: if `tcnt` = S-1, `tcnt` ← 0 and the next step is loaded. Otherwise `tcnt` ← `tcnt`+1.
- Next step index: 0 if `step_idx` ≥ `len`, else `step_idx`+1.
  - Shortening `len` during play wraps at the next boundary. There is no out-of-range access.
- The rest flag and count are sampled from memory only at step load.
  - A write to the playing step takes effect on its next play.
  - A write and a load of the same address on the same edge: the load sees the old data.
- `step_ticks`, `gate_ticks` and `len` are read live. A change takes effect at the next comparison.
  - If `tcnt` already exceeds the new S-1, the step ends at the next tick, because the end compare is `tcnt` ≥ S-1.
- `run`=0 in PLAY: go to IDLE and drop `trig` on the next edge. The next start always begins at step 0.
- Async reset at any time, including mid-step:
  - All outputs and state return to their reset values immediately.
  - Pattern memory returns to all rest.

## Timing
- Reset values: `trig`=0, `osc_count`=0, `step_idx`=0, `busy`=0, state IDLE, `tcnt`=0, prescaler 0.
- Start latency: `run` sampled high at edge N gives `busy`, `step_idx`=0, `osc_count` and `trig` valid after edge N+1 (one register stage).
- Step period is exactly S×TICK_DIV clock cycles. `trig` high time is G×TICK_DIV cycles.
- Step boundary: `step_idx`, `osc_count` and the rising `trig` all change on the same edge.
- Stop latency: `trig` goes low one cycle after `run` is sampled low.
- `tcnt` width is 16 bits. It never wraps because it is compared against S-1 ≤ 65534.

## Test plan
- Reset and idle: TICK_DIV=4. Write mem[0]=9'h042, then hold `run`=0 for 100 cycles -> `trig`=0, `busy`=0, `osc_count`=0 throughout.
- Basic play: TICK_DIV=4, `step_ticks`=4, `gate_ticks`=2, `len`=1, mem[0]=0x42, mem[1]=0x21. Raise `run` ->
  - `trig` high 8 cycles, then low 8, repeating every 16 cycles.
  - `osc_count` alternates 0x42/0x21 every 16 cycles.
  - `step_idx` alternates 0/1.
- Rest and gate clamp:
  - mem[1]=9'h100 with `gate_ticks`=10 and `step_ticks`=4 -> step 0 has `trig` high 12 cycles and low 4.
  - In step 1, `trig` stays low and `osc_count` holds 0x42.
- Length change and wrap:
  - `len`=15 while playing step 9, then set `len`=3 -> the next step is 0.
  - Setting `step_ticks`=0 -> one tick per step and `trig` never asserts.
- Stop/restart and mid-op reset:
  - Drop `run` in step 2 -> `trig`=0 on the next cycle and `busy`=0. Raise `run` again -> playback restarts at step 0.
  - Assert `rst` low mid-gate -> all outputs are 0 immediately, and memory reads back as rest.
- Write during play: overwrite the playing step's entry -> current `osc_count` is unchanged, and the new value appears on that step's next play.
